inst_issue_fifo: RTL and testbench

- Dual-ported instruction queue between the fetch stage and the two decode stages: the master pipeline and the slave pipeline_beta.
- Accepts up to 2 fetched instructions per cycle and presents the 2 oldest entries in show-ahead form: slot 1 feeds the master pipeline, slot 2 feeds the slave pipeline.
- Issue logic pops 0, 1 or 2 entries per cycle.
- Slot 2 drives the slave's instruction, pc_address and is_real_instruction inputs.

---
 rtl/inst_issue_fifo.sv | 127 ++++++++++++
 tb/tb_inst_issue_fifo.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/inst_issue_fifo.sv
// Dual-ported instruction issue queue between fetch and the two decode pipelines.
// Fetch pushes up to two instructions per cycle. The two oldest entries are presented
// show-ahead: slot 1 feeds the master pipeline and slot 2 feeds the slave pipeline_beta.
// Issue pops 0, 1 or 2 entries per cycle. Flush discards everything in one cycle.
module inst_issue_fifo #(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             write_en1,
  input  logic             write_en2,
  input  logic [31:0]      write_inst1,
  input  logic [31:0]      write_pc1,
  input  logic [31:0]      write_inst2,
  input  logic [31:0]      write_pc2,
  input  logic             read_en1,
  input  logic             read_en2,
  output logic [31:0]      read_inst1,
  output logic [31:0]      read_pc1,
  output logic             read_valid1,
  output logic [31:0]      read_inst2,
  output logic [31:0]      read_pc2,
  output logic             read_valid2,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  localparam int unsigned CntW = PTR_W + 1;

  // Storage is split so each entry's inst and pc are written together.
  logic [31:0]      mem_inst_q [DEPTH];
  logic [31:0]      mem_pc_q   [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CntW-1:0]  count_q, count_d;

  logic [PTR_W-1:0] head_nxt;
  logic [PTR_W-1:0] tail_nxt;
  logic [1:0]       push_num;
  logic [1:0]       pop_num;
  logic             wr_ok;
  logic             wr_first;
  logic             wr_second;

  // Flags come from the registered count only, so a same-cycle pop never unblocks a write.
  always_comb begin
    full  = (count_q > CntW'(DEPTH - 2));
    empty = (count_q == '0);
  end

  // Pointer successors wrap naturally because DEPTH is a power of two.
  always_comb begin
    head_nxt = head_q + PTR_W'(1);
    tail_nxt = tail_q + PTR_W'(1);
  end

  // Decide how many entries are pushed and popped this cycle.
  always_comb begin
    wr_ok     = ~full & ~flush;
    wr_first  = wr_ok & write_en1;
    // A lone write_en2 is meaningless: entry 2 always lands behind entry 1.
    wr_second = wr_first & write_en2;
    push_num  = 2'd0;
    if (wr_first) begin
      push_num = wr_second ? 2'd2 : 2'd1;
    end

    pop_num = 2'd0;
    if (read_en1 && (count_q != '0)) begin
      // Slot 2 can only be popped if it was visible at the start of the cycle.
      pop_num = (read_en2 && (count_q >= CntW'(2))) ? 2'd2 : 2'd1;
    end
  end

  // Next-state for pointers and occupancy; flush overrides everything.
  always_comb begin
    head_d  = head_q + PTR_W'(pop_num);
    tail_d  = tail_q + PTR_W'(push_num);
    count_d = count_q + CntW'(push_num) - CntW'(pop_num);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Pointer and occupancy registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; intentionally not reset since valid-gating hides stale contents.
  always_ff @(posedge clk) begin
    if (wr_first) begin
      mem_inst_q[tail_q] <= write_inst1;
      mem_pc_q[tail_q]   <= write_pc1;
    end
    if (wr_second) begin
      mem_inst_q[tail_nxt] <= write_inst2;
      mem_pc_q[tail_nxt]   <= write_pc2;
    end
  end

  // Show-ahead read ports; an empty slot reads as NOP at pc 0.
  always_comb begin
    read_valid1 = (count_q >= CntW'(1));
    read_valid2 = (count_q >= CntW'(2));
    read_inst1  = read_valid1 ? mem_inst_q[head_q]   : 32'd0;
    read_pc1    = read_valid1 ? mem_pc_q[head_q]     : 32'd0;
    read_inst2  = read_valid2 ? mem_inst_q[head_nxt] : 32'd0;
    read_pc2    = read_valid2 ? mem_pc_q[head_nxt]   : 32'd0;
    count       = count_q;
  end

endmodule

// File: tb/tb_inst_issue_fifo.sv
// Bench for inst_issue_fifo: directed scenarios followed by randomized traffic,
// all checked against a queue-based reference model of the issue queue.
module tb_inst_issue_fifo;

  localparam int unsigned DEPTH = 16;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        write_en1, write_en2;
  logic [31:0] write_inst1, write_pc1, write_inst2, write_pc2;
  logic        read_en1, read_en2;
  logic [31:0] read_inst1, read_pc1, read_inst2, read_pc2;
  logic        read_valid1, read_valid2;
  logic        full, empty;
  logic [4:0]  count;

  int n_vec;
  int n_err;

  // Reference model: oldest entry at index 0, each entry {inst, pc}.
  logic [63:0] mq[$];

  inst_issue_fifo #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .write_en1  (write_en1),
    .write_en2  (write_en2),
    .write_inst1(write_inst1),
    .write_pc1  (write_pc1),
    .write_inst2(write_inst2),
    .write_pc2  (write_pc2),
    .read_en1   (read_en1),
    .read_en2   (read_en2),
    .read_inst1 (read_inst1),
    .read_pc1   (read_pc1),
    .read_valid1(read_valid1),
    .read_inst2 (read_inst2),
    .read_pc2   (read_pc2),
    .read_valid2(read_valid2),
    .full       (full),
    .empty      (empty),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model's view of the queue.
  task automatic check_all(input string tag);
    int sz;
    logic [63:0] e0, e1;
    sz = mq.size();
    e0 = (sz >= 1) ? mq[0] : 64'd0;
    e1 = (sz >= 2) ? mq[1] : 64'd0;
    chk({tag, ".count"}, 32'(count), 32'(sz));
    chk({tag, ".empty"}, 32'(empty), 32'(sz == 0));
    chk({tag, ".full"},  32'(full),  32'(sz > DEPTH - 2));
    chk({tag, ".valid1"}, 32'(read_valid1), 32'(sz >= 1));
    chk({tag, ".valid2"}, 32'(read_valid2), 32'(sz >= 2));
    chk({tag, ".inst1"}, read_inst1, e0[63:32]);
    chk({tag, ".pc1"},   read_pc1,   e0[31:0]);
    chk({tag, ".inst2"}, read_inst2, e1[63:32]);
    chk({tag, ".pc2"},   read_pc2,   e1[31:0]);
  endtask

  task automatic idle();
    flush = 0; write_en1 = 0; write_en2 = 0; read_en1 = 0; read_en2 = 0;
    write_inst1 = 0; write_pc1 = 0; write_inst2 = 0; write_pc2 = 0;
  endtask

  // One clock cycle: drive inputs, advance the model from the pre-edge state, then check.
  task automatic step(input string tag, input logic we1, input logic we2,
                      input logic [31:0] i1, input logic [31:0] p1,
                      input logic [31:0] i2, input logic [31:0] p2,
                      input logic re1, input logic re2, input logic fl);
    int  sz;
    bit  was_full;
    flush = fl; write_en1 = we1; write_en2 = we2; read_en1 = re1; read_en2 = re2;
    write_inst1 = i1; write_pc1 = p1; write_inst2 = i2; write_pc2 = p2;
    sz = mq.size();
    was_full = (sz > DEPTH - 2);
    if (fl) begin
      mq.delete();
    end else begin
      if (re1 && sz >= 1) void'(mq.pop_front());
      if (re1 && re2 && sz >= 2) void'(mq.pop_front());
      if (!was_full && we1) begin
        mq.push_back({i1, p1});
        if (we2) mq.push_back({i2, p2});
      end
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    idle();
    rst = 1'b0;
    #12;
    check_all("reset");
    rst = 1'b1;

    // Dual write after reset.
    step("dual_wr", 1, 1, 32'h24010001, 32'hBFC00000, 32'h24020002, 32'hBFC00004, 0, 0, 0);
    chk("tp1.pc1", read_pc1, 32'hBFC00000);
    chk("tp1.inst2", read_inst2, 32'h24020002);

    // Dual read with only one entry pops just one.
    step("flush0", 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("push1", 1, 0, 32'hAAAA0001, 32'h00000010, 32'hDEAD, 32'hBEEF, 0, 0, 0);
    step("pop_short", 0, 0, 0, 0, 0, 0, 1, 1, 0);
    chk("tp2.inst1", read_inst1, 32'd0);

    // Lone write_en2 and lone read_en2 are ignored.
    step("we2_only", 0, 1, 32'h1, 32'h2, 32'h3, 32'h4, 0, 0, 0);
    step("push_a", 1, 0, 32'h11, 32'h20, 0, 0, 0, 0, 0);
    step("re2_only", 0, 0, 0, 0, 0, 0, 0, 1, 0);

    // Fill to full, then blocked writes.
    step("flush1", 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      step("fill", 1, 1, 32'h1000 + 32'(2*i), 32'h400 + 32'(8*i),
           32'h1001 + 32'(2*i), 32'h404 + 32'(8*i), 0, 0, 0);
    end
    chk("tp3.count16", 32'(count), 32'd16);
    step("wr_full", 1, 1, 32'hBAD0, 32'hBAD4, 32'hBAD8, 32'hBADC, 0, 0, 0);
    step("rw_full", 1, 1, 32'hBAD1, 32'hBAD5, 32'hBAD9, 32'hBADD, 1, 1, 0);
    chk("tp3.count14", 32'(count), 32'd14);

    // Wrap: walk head and tail to DEPTH-1, then dual write across the boundary.
    step("flush2", 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("w_push", 1, 0, 32'h50, 32'h50, 0, 0, 0, 0, 0);
    for (int i = 0; i < 14; i++) begin
      step("w_bal", 1, 0, 32'h60 + 32'(i), 32'h60 + 32'(i), 0, 0, 1, 0, 0);
    end
    step("w_pop", 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step("w_dual", 1, 1, 32'h7700, 32'h100, 32'h7704, 32'h104, 0, 0, 0);
    chk("tp4.pc1", read_pc1, 32'h100);
    chk("tp4.pc2", read_pc2, 32'h104);
    step("w_pop2", 1, 1, 32'h7708, 32'h108, 32'h770C, 32'h10C, 1, 1, 0);

    // Flush beats a same-cycle dual write.
    step("flush3", 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("f_a", 1, 1, 32'hA1, 32'hA1, 32'hA2, 32'hA2, 0, 0, 0);
    step("f_b", 1, 1, 32'hA3, 32'hA3, 32'hA4, 32'hA4, 0, 0, 0);
    step("f_c", 1, 0, 32'hA5, 32'hA5, 0, 0, 0, 0, 0);
    step("f_flush", 1, 1, 32'hEE, 32'hEE, 32'hEF, 32'hEF, 1, 1, 1);
    chk("tp5.empty", 32'(empty), 32'd1);

    // Asynchronous reset between edges with count 6.
    for (int i = 0; i < 3; i++) begin
      step("r_fill", 1, 1, 32'hC0 + 32'(i), 32'hD0 + 32'(i), 32'hC8 + 32'(i), 32'hD8 + 32'(i),
           0, 0, 0);
    end
    idle();
    #3;
    rst = 1'b0;
    mq.delete();
    #1;
    check_all("async_rst");
    #2;
    rst = 1'b1;
    step("post_rst", 1, 0, 32'hF00D, 32'h200, 0, 0, 0, 0, 0);
    chk("tp6.count1", 32'(count), 32'd1);

    // Randomized traffic with phases biased toward filling and draining.
    for (int i = 0; i < 600; i++) begin
      int wp;
      case ((i / 100) % 3)
        0:       wp = 80;
        1:       wp = 20;
        default: wp = 50;
      endcase
      step("rand",
           ($urandom_range(99) < wp), ($urandom_range(99) < 60),
           $urandom, $urandom, $urandom, $urandom,
           ($urandom_range(99) >= wp), ($urandom_range(99) < 60),
           ($urandom_range(39) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
